lif_array: RTL and testbench
============================

# lif_array

Parametrised array of leaky integrate-and-fire neurons sharing one time-multiplexed update datapath. Each accepted timestep integrates one input current per channel, applies shift-based leak, saturating arithmetic, a programmable threshold and a refractory period, then publishes a spike vector. It is the multi-channel successor of the single-neuron LIF core and sits between the input-current front end and the spike output pins.

## Interface
- N_CH, 4, number of neuron channels (≥1)
- W, 8, membrane/current/threshold width in bits
- LEAK_SHIFT, 1, leak = state >> LEAK_SHIFT per step (1..W-1)
- REFRAC, 2, refractory length in timesteps after a spike (0 = none)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- step_valid  in  1  request one timestep
- step_ready  out  1  high in IDLE; step accepted on valid&&ready
- current  in  N_CH*W  channel i current at [i*W +: W], unsigned
- threshold  in  W  firing threshold, unsigned, shared by all channels
- inhibit  in  W  lateral inhibition amount (used only with LIF_ARRAY_INHIBIT_EN)
- spike  out  N_CH  spike vector of the last completed step, registered
- spike_valid  out  1  one-cycle pulse when spike is updated
- state_sel  in  clog2(N_CH) (min 1)  readback channel select
- state_out  out  W  membrane state of channel state_sel, combinational

## Operation
- FSM: IDLE → UPDATE → DONE → IDLE.
- IDLE: step_ready=1. On accept, capture current and threshold, clear spike shadow, idx←0, go UPDATE.
- UPDATE: one channel per cycle, idx 0..N_CH-1; after idx=N_CH-1 go DONE.
- Channel update, refractory (rc>0): rc←rc-1, state←0, no spike.
- Channel update, otherwise: sum = state - (state>>LEAK_SHIFT) + current in W+1 bits, saturate to 2^W-1. If sum ≥ threshold: spike bit set, state←0, rc←REFRAC. Else state←sum.
- threshold=0: every non-refractory channel fires each step.
- DONE: spike←shadow, spike_valid←1 for one cycle, go IDLE.
- step_valid while not in IDLE is ignored (no queuing).
- state_out reads live storage; mid-step it shows partially updated values.

## Timing
- Reset: state=0, rc=0 all channels; spike=0; spike_valid=0; FSM=IDLE so step_ready=1 from the first cycle after reset.
- Accept at edge E0; channel i updated at edge E(i+1); spike/spike_valid registered at edge E(N_CH+1).
- Latency accept → spike_valid visible: N_CH+1 cycles. Throughput: one step per N_CH+2 cycles with step_valid held high.
- Reset asserted mid-step: step abandoned, no spike_valid, all state cleared at that edge.
- Inputs current/threshold may change freely after accept.

## Configuration
- LIF_ARRAY_INHIBIT_EN defined: in DONE, if any spike bit set, each non-spiking, non-refractory channel has state ← max(state - inhibit, 0), same edge as spike_valid.
- Undefined: no inhibition logic; inhibit input unused; DONE only publishes spikes.

## Structure
- Package lif_pkg: FSM state enum (IDLE, UPDATE, DONE), saturation helper function, default parameter constants.
- Sub-module lif_update: combinational single-neuron step (leak, integrate, saturate, compare, refractory decrement) taking state, rc, current, threshold; returns next state, next rc, spike. lif_array owns FSM, storage, capture and inhibition.

## Test plan
All with N_CH=4, W=8, LEAK_SHIFT=1, REFRAC=2, threshold=100 unless noted.
- Reset: hold rst_n low 2 cycles → spike=0, spike_valid=0, step_ready=1, state_out=0 for every state_sel.
- Sub-threshold leak: ch0 current=40 for 6 steps → states 40,60,70,75,78,79; never spikes.
- Fire + refractory: ch1 current=60 → states 60,90, then spike on step 3 (sum 105), state 0; steps 4,5 no spike, state 0; step 6 state 60.
- Saturation: threshold=255, ch2 current=200 → step1 state 200, step2 sum 300 saturates to 255, spikes, state 0.
- Handshake/latency: step_valid held high 3 steps → accepts every 6 cycles, spike_valid exactly one cycle each, 5 cycles after accept; rst_n low at E2 of a step → no spike_valid, all states 0.
- LIF_ARRAY_INHIBIT_EN, inhibit=30: ch1 spikes while ch0 state 70 and ch3 state 10 → ch0 becomes 40, ch3 becomes 0 at spike_valid edge; without macro both unchanged.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the lif_array neuron block: FSM state encoding,
// default parameter values and the unsigned saturation helper.
package lif_pkg;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_W          = 8;
    localparam int DEF_LEAK_SHIFT = 1;
    localparam int DEF_REFRAC     = 2;

    // Widest membrane supported by the saturation helper.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    // Clamp a (w+1)-bit unsigned sum, zero-extended to MAX_W+1 bits, to 2^w-1.
    function automatic logic [MAX_W-1:0] sat_clip(input logic [MAX_W:0] sum,
                                                  input int unsigned w);
        logic [MAX_W:0] lim;
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        if (sum > lim) begin
            return lim[MAX_W-1:0];
        end
        return sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_array_if.sv
// Step handshake, channel currents, shared threshold/inhibit, spike output
// and membrane readback for lif_array.
interface lif_array_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                step_valid;
    logic                step_ready;
    logic [N_CH*W-1:0]   current;
    logic [W-1:0]        threshold;
    logic [W-1:0]        inhibit;
    logic [N_CH-1:0]     spike;
    logic                spike_valid;
    logic [SEL_W-1:0]    state_sel;
    logic [W-1:0]        state_out;

    modport master (
        output step_valid, current, threshold, inhibit, state_sel,
        input  step_ready, spike, spike_valid, state_out
    );

    modport slave (
        input  step_valid, current, threshold, inhibit, state_sel,
        output step_ready, spike, spike_valid, state_out
    );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron timestep: shift leak, integrate current,
// saturate, compare against threshold, and count down the refractory period.
module lif_update
    import lif_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC,
    parameter int RC_W       = 2
) (
    input  logic [W-1:0]    state_in,
    input  logic [RC_W-1:0] rc_in,
    input  logic [W-1:0]    current,
    input  logic [W-1:0]    threshold,
    output logic [W-1:0]    state_next,
    output logic [RC_W-1:0] rc_next,
    output logic            spike
);
    logic [W-1:0] leaked;
    logic [W:0]   sum;
    logic [W-1:0] sat;

    assign leaked = state_in - (state_in >> LEAK_SHIFT);
    assign sum    = {1'b0, leaked} + {1'b0, current};
    assign sat    = W'(sat_clip((MAX_W+1)'(sum), W));

    // Refractory channels are held at zero; otherwise fire or integrate.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_next = sat;
        rc_next    = rc_in;
        spike      = 1'b0;
        if (rc_in != '0) begin
            state_next = '0;
            rc_next    = rc_in - RC_W'(1);
        end else if (sat >= threshold) begin
            spike      = 1'b1;
            state_next = '0;
            rc_next    = RC_W'(REFRAC);
        end
    end
endmodule

// File: rtl/lif_array.sv
// Array of N_CH leaky integrate-and-fire neurons sharing one lif_update
// datapath, one channel per cycle. Optional lateral inhibition is enabled
// with the LIF_ARRAY_INHIBIT_EN macro.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int W          = DEF_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC
) (
    input  logic        clk,
    input  logic        rst_n,
    lif_array_if.slave  bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int RC_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    lif_state_e          state_q, state_d;
    logic [SEL_W-1:0]    idx_q;
    logic [N_CH*W-1:0]   cur_q;
    logic [W-1:0]        thr_q;
    logic [N_CH-1:0]     shadow_q;
    logic [N_CH-1:0]     spike_q;
    logic                spike_valid_q;
    logic [W-1:0]        mem_state [N_CH];
    logic [RC_W-1:0]     mem_rc    [N_CH];

    logic [W-1:0]        upd_state;
    logic [RC_W-1:0]     upd_rc;
    logic                upd_spike;

    lif_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .RC_W       (RC_W)
    ) u_update (
        .state_in   (mem_state[idx_q]),
        .rc_in      (mem_rc[idx_q]),
        .current    (cur_q[idx_q*W +: W]),
        .threshold  (thr_q),
        .state_next (upd_state),
        .rc_next    (upd_rc),
        .spike      (upd_spike)
    );

    assign bus.step_ready  = (state_q == IDLE);
    assign bus.spike       = spike_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.state_out   = mem_state[bus.state_sel];

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, sweep channels, publish, return.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.step_valid) state_d = UPDATE;
            UPDATE:  if (idx_q == SEL_W'(N_CH - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifndef LIF_ARRAY_INHIBIT_EN
    logic unused_inhibit;
    assign unused_inhibit = ^bus.inhibit;
`endif

    // Datapath: capture on accept, write back one channel per cycle, publish in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: neuron storage is a small flop array and must start from rest, so it is reset too.
            for (int i = 0; i < N_CH; i++) begin
                mem_state[i] <= '0;
                mem_rc[i]    <= '0;
            end
            idx_q         <= '0;
            cur_q         <= '0;
            thr_q         <= '0;
            shadow_q      <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
        end else begin
            spike_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.step_valid) begin
                        cur_q    <= bus.current;
                        thr_q    <= bus.threshold;
                        shadow_q <= '0;
                        idx_q    <= '0;
                    end
                end
                UPDATE: begin
                    mem_state[idx_q] <= upd_state;
                    mem_rc[idx_q]    <= upd_rc;
                    shadow_q[idx_q]  <= upd_spike;
                    idx_q            <= idx_q + SEL_W'(1);
                end
                DONE: begin
                    spike_q       <= shadow_q;
                    spike_valid_q <= 1'b1;
`ifdef LIF_ARRAY_INHIBIT_EN
                    if (|shadow_q) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (!shadow_q[i] && (mem_rc[i] == '0)) begin
                                mem_state[i] <= (mem_state[i] > bus.inhibit) ?
                                                mem_state[i] - bus.inhibit : '0;
                            end
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_array.sv
// Directed testbench for lif_array (N_CH=4, W=8, LEAK_SHIFT=1, REFRAC=2).
// Expected values are hand-computed; build with LIF_ARRAY_INHIBIT_EN to
// exercise the inhibition expectations.
module tb_lif_array;
    localparam int N_CH = 4;
    localparam int W    = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    lif_array_if #(.N_CH(N_CH), .W(W)) bus ();

    lif_array #(.N_CH(N_CH), .W(W), .LEAK_SHIFT(1), .REFRAC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;   // reset before applying this step
        logic [31:0] cur;   // ch3..ch0 currents
        logic [7:0]  thr;
        logic [3:0]  spk;   // expected spike vector
        logic [31:0] st;    // expected ch3..ch0 membrane after the step
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.step_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_state(input int ch, output logic [7:0] val);
        bus.state_sel = 2'(ch);
        #1;
        val = bus.state_out;
    endtask

    // Runs one timestep from a negedge; returns at the negedge where spike_valid is seen.
    task automatic do_step(input logic [31:0] cur, input logic [7:0] thr,
                           input logic [7:0] inh, output logic [3:0] spk);
        int k;
        k = 0;
        while (!bus.step_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        bus.current    = cur;
        bus.threshold  = thr;
        bus.inhibit    = inh;
        bus.step_valid = 1'b1;
        @(negedge clk);
        bus.step_valid = 1'b0;
        bus.current    = $urandom;
        bus.threshold  = 8'($urandom);
        k = 0;
        while (!bus.spike_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("step_latency", 32'(k), 32'd5);
        spk = bus.spike;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] spk;
        logic [7:0] val;
        logic [7:0] exp_st;
        int         acc_t [$];
        int         sv_t  [$];
        int         sv_cnt;

        n_vec  = 0;
        n_miss = 0;
        bus.step_valid = 1'b0;
        bus.current    = '0;
        bus.threshold  = '0;
        bus.inhibit    = '0;
        bus.state_sel  = '0;

        // Leak/fire/refractory on ch0/ch1, saturation on ch2, threshold=0 firing.
        tbl[0]  = '{1'b1, {8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 4'b0000, {8'd0, 8'd0, 8'd60, 8'd40}};
        tbl[1]  = '{1'b0, {8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 4'b0000, {8'd0, 8'd0, 8'd90, 8'd60}};
        tbl[2]  = '{1'b0, {8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 4'b0010, {8'd0, 8'd0, 8'd0, 8'd70}};
        tbl[3]  = '{1'b0, {8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd75}};
        tbl[4]  = '{1'b0, {8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd78}};
        tbl[5]  = '{1'b0, {8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 4'b0000, {8'd0, 8'd0, 8'd60, 8'd79}};
        tbl[6]  = '{1'b1, {8'd0, 8'd200, 8'd0, 8'd0}, 8'd255, 4'b0000, {8'd0, 8'd200, 8'd0, 8'd0}};
        tbl[7]  = '{1'b0, {8'd0, 8'd200, 8'd0, 8'd0}, 8'd255, 4'b0100, 32'd0};
        tbl[8]  = '{1'b1, 32'd0, 8'd0, 4'b1111, 32'd0};
        tbl[9]  = '{1'b0, 32'd0, 8'd0, 4'b0000, 32'd0};
        tbl[10] = '{1'b0, 32'd0, 8'd0, 4'b0000, 32'd0};
        tbl[11] = '{1'b0, 32'd0, 8'd0, 4'b1111, 32'd0};

        // Reset state.
        apply_reset();
        check("reset_spike", 32'(bus.spike), 32'd0);
        check("reset_spike_valid", 32'(bus.spike_valid), 32'd0);
        check("reset_step_ready", 32'(bus.step_ready), 32'd1);
        for (int c = 0; c < N_CH; c++) begin
            read_state(c, val);
            check($sformatf("reset_state_ch%0d", c), 32'(val), 32'd0);
        end

        // Table-driven steps.
        for (int v = 0; v < 12; v++) begin
            if (tbl[v].rst) apply_reset();
            do_step(tbl[v].cur, tbl[v].thr, 8'd0, spk);
            check($sformatf("vec%0d_spike", v), 32'(spk), 32'(tbl[v].spk));
            for (int c = 0; c < N_CH; c++) begin
                read_state(c, val);
                exp_st = tbl[v].st[c*8 +: 8];
                check($sformatf("vec%0d_state_ch%0d", v, c), 32'(val), 32'(exp_st));
            end
        end

        // Back-to-back steps with step_valid held high. Indices are negedges;
        // an accept sampled at t happens on the following edge, so spike_valid
        // (five edges later) is sampled at t+6.
        apply_reset();
        bus.current    = '0;
        bus.threshold  = 8'd200;
        bus.step_valid = 1'b1;
        sv_cnt = 0;
        for (int t = 0; t < 24; t++) begin
            if (bus.spike_valid) sv_t.push_back(t);
            if (bus.step_valid && bus.step_ready) acc_t.push_back(t);
            @(negedge clk);
            if (acc_t.size() >= 3) bus.step_valid = 1'b0;
        end
        check("hs_accept_count", 32'(acc_t.size()), 32'd3);
        check("hs_spike_valid_count", 32'(sv_t.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < acc_t.size()) check($sformatf("hs_accept_t%0d", k), 32'(acc_t[k]), 32'(6 * k));
            if (k < sv_t.size() && k < acc_t.size())
                check($sformatf("hs_sv_t%0d", k), 32'(sv_t[k]), 32'(acc_t[k] + 6));
        end

        // Reset sampled at E2 of a step: no spike_valid, all states cleared.
        apply_reset();
        do_step({8'd10, 8'd20, 8'd30, 8'd40}, 8'd200, 8'd0, spk);
        read_state(3, val);
        check("pre_abort_state_ch3", 32'(val), 32'd10);
        bus.current    = {8'd10, 8'd20, 8'd30, 8'd40};
        bus.threshold  = 8'd200;
        bus.step_valid = 1'b1;
        @(negedge clk);           // after E0
        bus.step_valid = 1'b0;
        @(negedge clk);           // after E1
        rst_n = 1'b0;
        @(negedge clk);           // after E2, reset taken
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (bus.spike_valid) sv_cnt++;
            @(negedge clk);
        end
        check("abort_spike_valid_count", 32'(sv_cnt), 32'd0);
        check("abort_step_ready", 32'(bus.step_ready), 32'd1);
        for (int c = 0; c < N_CH; c++) begin
            read_state(c, val);
            check($sformatf("abort_state_ch%0d", c), 32'(val), 32'd0);
        end

        // Lateral inhibition: ch1 fires while ch0=70 and ch3=10.
        apply_reset();
        do_step({8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 8'd30, spk);
        do_step({8'd0, 8'd0, 8'd60, 8'd40}, 8'd100, 8'd30, spk);
        do_step({8'd10, 8'd0, 8'd60, 8'd40}, 8'd100, 8'd30, spk);
        check("inh_spike", 32'(spk), 32'b0010);
`ifdef LIF_ARRAY_INHIBIT_EN
        read_state(0, val);
        check("inh_state_ch0", 32'(val), 32'd40);
        read_state(3, val);
        check("inh_state_ch3", 32'(val), 32'd0);
`else
        read_state(0, val);
        check("inh_state_ch0", 32'(val), 32'd70);
        read_state(3, val);
        check("inh_state_ch3", 32'(val), 32'd10);
`endif
        read_state(1, val);
        check("inh_state_ch1", 32'(val), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
